// File: rtl/eth_tx_pkg.sv
// Shared types and constants for the GMII transmit framer and its CRC-32 kernel.
// The byte-wise CRC step lives here so the kernel and any future users agree on it.
package eth_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_DATA,
        ST_PAD,
        ST_FCS,
        ST_IFG
    } tx_state_t;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    localparam int          FCS_LEN       = 4;

    // Reflected CRC-32: the byte enters LSB-first, one shift per bit.
    function automatic logic [31:0] crc32_d8_next(input logic [31:0] crc,
                                                  input logic [7:0]  data);
        logic [31:0] c;
        c = crc ^ {24'd0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/eth_crc32_d8.sv
// Byte-wide reflected CRC-32 register; o_crc is the raw register (no final inversion).
// A clear wins over an update in the same cycle.
module eth_crc32_d8
    import eth_tx_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clr,
    input  logic        i_en,
    input  logic [7:0]  i_data,
    output logic [31:0] o_crc
);

    logic [31:0] r_crc;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_crc <= CRC_INIT;
        end else if (i_clr) begin
            r_crc <= CRC_INIT;
        end else if (i_en) begin
            r_crc <= crc32_d8_next(r_crc, i_data);
        end
    end

    assign o_crc = r_crc;

endmodule

// File: rtl/mac_tx_frame_pack.sv
// GMII transmit framer: preamble/SFD, payload, zero pad, FCS and inter-frame gap.
// Handshake: a byte moves when i_valid & o_ready at a rising edge; o_ready is high only in DATA.
module mac_tx_frame_pack
    import eth_tx_pkg::*;
#(
    parameter int P_MIN_LEN = 60,
    parameter int P_IFG     = 12,
    parameter int P_PRE_LEN = 7
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    input  logic       i_last,
    output logic       o_ready,
    output logic [7:0] o_gmii_txd,
    output logic       o_gmii_txen,
    output logic       o_gmii_txer,
    output logic       o_busy,
    output logic       o_frame_done
);

    localparam logic [16:0] LP_MIN_LEN  = 17'(P_MIN_LEN);
    localparam logic [7:0]  LP_PRE_LAST = 8'(P_PRE_LEN);
    // A zero gap still spends one cycle in IFG so the state is always visible.
    localparam logic [15:0] LP_IFG_LAST = 16'((P_IFG > 0) ? (P_IFG - 1) : 0);

    tx_state_t   r_state, w_state_nxt;
    logic [15:0] r_cnt, w_cnt_nxt;
    logic [7:0]  r_pre_cnt, w_pre_cnt_nxt;
    logic [1:0]  r_fcs_idx, w_fcs_idx_nxt;
    logic [15:0] r_ifg_cnt, w_ifg_cnt_nxt;

    logic [7:0]  r_txd, w_txd_nxt;
    logic        r_txen, w_txen_nxt;
    logic        r_txer, w_txer_nxt;
    logic        r_done, w_done_nxt;

    logic        w_crc_clr;
    logic        w_crc_en;
    logic [7:0]  w_crc_data;
    logic [31:0] w_crc;
    logic [31:0] w_fcs;
    logic [16:0] w_cnt_plus1;
    logic [15:0] w_cnt_sat;

    eth_crc32_d8 u_crc (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clr  (w_crc_clr),
        .i_en   (w_crc_en),
        .i_data (w_crc_data),
        .o_crc  (w_crc)
    );

    assign w_fcs       = ~w_crc;
    assign w_cnt_plus1 = {1'b0, r_cnt} + 17'd1;
    assign w_cnt_sat   = (&r_cnt) ? r_cnt : w_cnt_plus1[15:0];

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_pre_cnt_nxt = r_pre_cnt;
        w_fcs_idx_nxt = r_fcs_idx;
        w_ifg_cnt_nxt = r_ifg_cnt;
        w_txd_nxt     = 8'h00;
        w_txen_nxt    = 1'b0;
        w_txer_nxt    = 1'b0;
        w_done_nxt    = 1'b0;
        w_crc_clr     = 1'b0;
        w_crc_en      = 1'b0;
        w_crc_data    = i_data;

        case (r_state)
            ST_IDLE: begin
                if (i_valid) begin
                    w_state_nxt   = ST_PRE;
                    w_crc_clr     = 1'b1;
                    w_cnt_nxt     = 16'd0;
                    w_pre_cnt_nxt = 8'd0;
                end
            end

            ST_PRE: begin
                w_txen_nxt = 1'b1;
                if (r_pre_cnt == LP_PRE_LAST) begin
                    w_txd_nxt   = SFD_BYTE;
                    w_state_nxt = ST_DATA;
                end else begin
                    w_txd_nxt     = PREAMBLE_BYTE;
                    w_pre_cnt_nxt = r_pre_cnt + 8'd1;
                end
            end

            ST_DATA: begin
                w_txen_nxt = 1'b1;
                if (i_valid) begin
                    w_txd_nxt = i_data;
                    w_crc_en  = 1'b1;
                    w_cnt_nxt = w_cnt_sat;
                    if (i_last) begin
                        w_fcs_idx_nxt = 2'd0;
                        w_state_nxt   = (w_cnt_plus1 < LP_MIN_LEN) ? ST_PAD : ST_FCS;
                    end
                end else begin
                    // Underrun: poison the frame on the wire and skip the FCS.
                    w_txd_nxt     = 8'h00;
                    w_txer_nxt    = 1'b1;
                    w_ifg_cnt_nxt = 16'd0;
                    w_state_nxt   = ST_IFG;
                end
            end

            ST_PAD: begin
                w_txen_nxt = 1'b1;
                w_txd_nxt  = 8'h00;
                w_crc_en   = 1'b1;
                w_crc_data = 8'h00;
                w_cnt_nxt  = w_cnt_sat;
                if (w_cnt_plus1 >= LP_MIN_LEN) begin
                    w_fcs_idx_nxt = 2'd0;
                    w_state_nxt   = ST_FCS;
                end
            end

            ST_FCS: begin
                w_txen_nxt = 1'b1;
                w_txd_nxt  = w_fcs[{r_fcs_idx, 3'b000} +: 8];
                if (r_fcs_idx == 2'(FCS_LEN - 1)) begin
                    w_done_nxt    = 1'b1;
                    w_ifg_cnt_nxt = 16'd0;
                    w_state_nxt   = ST_IFG;
                end else begin
                    w_fcs_idx_nxt = r_fcs_idx + 2'd1;
                end
            end

            ST_IFG: begin
                if (r_ifg_cnt == LP_IFG_LAST) begin
                    // Going straight to PRE keeps the gap exactly P_IFG cycles back to back.
                    if (i_valid) begin
                        w_state_nxt   = ST_PRE;
                        w_crc_clr     = 1'b1;
                        w_cnt_nxt     = 16'd0;
                        w_pre_cnt_nxt = 8'd0;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_ifg_cnt_nxt = r_ifg_cnt + 16'd1;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 16'd0;
            r_pre_cnt <= 8'd0;
            r_fcs_idx <= 2'd0;
            r_ifg_cnt <= 16'd0;
            r_txd     <= 8'h00;
            r_txen    <= 1'b0;
            r_txer    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_pre_cnt <= w_pre_cnt_nxt;
            r_fcs_idx <= w_fcs_idx_nxt;
            r_ifg_cnt <= w_ifg_cnt_nxt;
            r_txd     <= w_txd_nxt;
            r_txen    <= w_txen_nxt;
            r_txer    <= w_txer_nxt;
            r_done    <= w_done_nxt;
        end
    end

    assign o_ready      = (r_state == ST_DATA);
    assign o_busy       = (r_state != ST_IDLE);
    assign o_gmii_txd   = r_txd;
    assign o_gmii_txen  = r_txen;
    assign o_gmii_txer  = r_txer;
    assign o_frame_done = r_done;

endmodule

// File: tb/tb_mac_tx_frame_pack.sv
// Directed bench for mac_tx_frame_pack: dut0 runs without padding, dut1 with default parameters.
// Outputs are sampled on the falling edge; inputs are driven on the falling edge.
module tb_mac_tx_frame_pack;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [7:0] d0_data, d1_data;
    logic       d0_valid, d0_last, d1_valid, d1_last;
    logic       d0_ready, d0_txen, d0_txer, d0_busy, d0_done;
    logic       d1_ready, d1_txen, d1_txer, d1_busy, d1_done;
    logic [7:0] d0_txd, d1_txd;

    mac_tx_frame_pack #(.P_MIN_LEN(0), .P_IFG(12), .P_PRE_LEN(7)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_data(d0_data), .i_valid(d0_valid), .i_last(d0_last),
        .o_ready(d0_ready), .o_gmii_txd(d0_txd), .o_gmii_txen(d0_txen),
        .o_gmii_txer(d0_txer), .o_busy(d0_busy), .o_frame_done(d0_done)
    );

    mac_tx_frame_pack dut1 (
        .i_clk(clk), .i_rst(rst), .i_data(d1_data), .i_valid(d1_valid), .i_last(d1_last),
        .o_ready(d1_ready), .o_gmii_txd(d1_txd), .o_gmii_txen(d1_txen),
        .o_gmii_txer(d1_txer), .o_busy(d1_busy), .o_frame_done(d1_done)
    );

    logic [8:0] stim_q[$];
    logic [7:0] s_txd[$];
    logic       s_txen[$], s_txer[$], s_done[$], s_busy[$];
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int acc_cnt, ready_cnt;
    int n_cmp = 0;
    int n_err = 0;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Bit-serial reference FCS (complemented, reflected CRC-32).
    function automatic logic [31:0] ref_fcs(input logic [7:0] b[$]);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFFFFFF;
        foreach (b[i]) begin
            for (int k = 0; k < 8; k++) begin
                fb = c[0] ^ b[i][k];
                c  = {1'b0, c[31:1]} ^ (fb ? 32'hEDB88320 : 32'h0);
            end
        end
        return ~c;
    endfunction

    function automatic logic flag_at(input int which, input int i);
        case (which)
            0:       return s_txen[i];
            1:       return s_txer[i];
            2:       return s_done[i];
            default: return s_busy[i];
        endcase
    endfunction

    function automatic int count_flag(input int which);
        int n;
        n = 0;
        for (int i = 0; i < s_txen.size(); i++) if (flag_at(which, i)) n++;
        return n;
    endfunction

    function automatic int first_flag(input int which, input int from);
        for (int i = from; i < s_txen.size(); i++) if (flag_at(which, i)) return i;
        return -1;
    endfunction

    function automatic int last_flag(input int which);
        int li;
        li = -1;
        for (int i = 0; i < s_txen.size(); i++) if (flag_at(which, i)) li = i;
        return li;
    endfunction

    function automatic int first_diff();
        int n;
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (got_q[i] !== exp_q[i]) return i;
        if (got_q.size() != exp_q.size()) return n;
        return -1;
    endfunction

    task automatic collect_high();
        got_q.delete();
        foreach (s_txen[i]) if (s_txen[i]) got_q.push_back(s_txd[i]);
    endtask

    task automatic push_pre();
        for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
    endtask

    task automatic push_fcs(input logic [31:0] f);
        exp_q.push_back(f[7:0]);
        exp_q.push_back(f[15:8]);
        exp_q.push_back(f[23:16]);
        exp_q.push_back(f[31:24]);
    endtask

    task automatic push_check_frame();
        for (int i = 0; i < 9; i++) stim_q.push_back({(i == 8), 8'(8'h31 + i)});
    endtask

    // Drives stim_q through the chosen DUT and records every falling-edge sample.
    task automatic run_stream(input bit sel, input int max_cycles, output bit finished);
        int  idx;
        bit  prev_acc, seen_busy, v, rdy, bsy;
        s_txd.delete(); s_txen.delete(); s_txer.delete(); s_done.delete(); s_busy.delete();
        idx = 0; prev_acc = 0; seen_busy = 0; finished = 0;
        acc_cnt = 0; ready_cnt = 0;
        for (int cyc = 0; cyc < max_cycles; cyc++) begin
            @(negedge clk);
            if (prev_acc) idx++;
            if (sel) begin
                s_txd.push_back(d1_txd); s_txen.push_back(d1_txen); s_txer.push_back(d1_txer);
                s_done.push_back(d1_done); s_busy.push_back(d1_busy);
                rdy = d1_ready; bsy = d1_busy;
            end else begin
                s_txd.push_back(d0_txd); s_txen.push_back(d0_txen); s_txer.push_back(d0_txer);
                s_done.push_back(d0_done); s_busy.push_back(d0_busy);
                rdy = d0_ready; bsy = d0_busy;
            end
            if (rdy) ready_cnt++;
            if (bsy) seen_busy = 1;
            if (idx >= stim_q.size() && seen_busy && !bsy) begin
                finished = 1;
                break;
            end
            v = (idx < stim_q.size());
            if (sel) begin
                d1_valid = v; d1_data = v ? stim_q[idx][7:0] : 8'h00; d1_last = v ? stim_q[idx][8] : 1'b0;
            end else begin
                d0_valid = v; d0_data = v ? stim_q[idx][7:0] : 8'h00; d0_last = v ? stim_q[idx][8] : 1'b0;
            end
            prev_acc = v && rdy;
            if (prev_acc) acc_cnt++;
        end
        d0_valid = 0; d0_data = 8'h00; d0_last = 0;
        d1_valid = 0; d1_data = 8'h00; d1_last = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        d0_valid = 0; d0_data = 8'h00; d0_last = 0;
        d1_valid = 0; d1_data = 8'h00; d1_last = 0;
        repeat (3) @(negedge clk);
        n_cmp++; if (d0_txd !== 8'h00) begin n_err++; $display("FAIL reset_d0_txd got=%02h exp=00", d0_txd); end
        n_cmp++; if (d0_txen !== 1'b0) begin n_err++; $display("FAIL reset_d0_txen got=%b exp=0", d0_txen); end
        n_cmp++; if (d0_txer !== 1'b0) begin n_err++; $display("FAIL reset_d0_txer got=%b exp=0", d0_txer); end
        n_cmp++; if (d0_ready !== 1'b0) begin n_err++; $display("FAIL reset_d0_ready got=%b exp=0", d0_ready); end
        n_cmp++; if (d0_busy !== 1'b0) begin n_err++; $display("FAIL reset_d0_busy got=%b exp=0", d0_busy); end
        n_cmp++; if (d0_done !== 1'b0) begin n_err++; $display("FAIL reset_d0_done got=%b exp=0", d0_done); end
        n_cmp++; if (d1_txd !== 8'h00) begin n_err++; $display("FAIL reset_d1_txd got=%02h exp=00", d1_txd); end
        n_cmp++; if (d1_txen !== 1'b0) begin n_err++; $display("FAIL reset_d1_txen got=%b exp=0", d1_txen); end
        n_cmp++; if (d1_ready !== 1'b0) begin n_err++; $display("FAIL reset_d1_ready got=%b exp=0", d1_ready); end
        n_cmp++; if (d1_busy !== 1'b0) begin n_err++; $display("FAIL reset_d1_busy got=%b exp=0", d1_busy); end
        rst = 0;
        repeat (2) @(negedge clk);
        n_cmp++; if (d0_busy !== 1'b0) begin n_err++; $display("FAIL post_reset_idle got=%b exp=0", d0_busy); end
    endtask

    task automatic test_check_value();
        bit fin;
        int d;
        stim_q.delete(); push_check_frame();
        run_stream(0, 200, fin);
        exp_q.delete(); push_pre();
        for (int i = 0; i < 9; i++) exp_q.push_back(8'(8'h31 + i));
        exp_q.push_back(8'h26); exp_q.push_back(8'h39); exp_q.push_back(8'hF4); exp_q.push_back(8'hCB);
        collect_high(); d = first_diff();
        n_cmp++; if (!fin) begin n_err++; $display("FAIL chk_timeout got=unfinished exp=finished"); end
        n_cmp++; if (count_flag(0) != 21) begin n_err++; $display("FAIL chk_txen_cycles got=%0d exp=21", count_flag(0)); end
        n_cmp++; if (last_flag(0) - first_flag(0, 0) + 1 != 21) begin n_err++; $display("FAIL chk_contiguous got=%0d exp=21", last_flag(0) - first_flag(0, 0) + 1); end
        n_cmp++; if (d != -1) begin n_err++; $display("FAIL chk_seq idx=%0d got=%02h exp=%02h", d, (d < got_q.size()) ? got_q[d] : 8'hxx, (d < exp_q.size()) ? exp_q[d] : 8'hxx); end
        n_cmp++; if (count_flag(2) != 1) begin n_err++; $display("FAIL chk_done_count got=%0d exp=1", count_flag(2)); end
        n_cmp++; if (first_flag(2, 0) != last_flag(0)) begin n_err++; $display("FAIL chk_done_pos got=%0d exp=%0d", first_flag(2, 0), last_flag(0)); end
        n_cmp++; if (count_flag(1) != 0) begin n_err++; $display("FAIL chk_txer got=%0d exp=0", count_flag(1)); end
    endtask

    task automatic test_min_pad();
        bit fin;
        int d;
        logic [7:0] body[$];
        stim_q.delete(); stim_q.push_back({1'b1, 8'hAB});
        run_stream(1, 300, fin);
        body.delete(); body.push_back(8'hAB);
        for (int i = 0; i < 59; i++) body.push_back(8'h00);
        exp_q.delete(); push_pre();
        foreach (body[i]) exp_q.push_back(body[i]);
        push_fcs(ref_fcs(body));
        collect_high(); d = first_diff();
        n_cmp++; if (!fin) begin n_err++; $display("FAIL pad_timeout got=unfinished exp=finished"); end
        n_cmp++; if (count_flag(0) != 72) begin n_err++; $display("FAIL pad_txen_cycles got=%0d exp=72", count_flag(0)); end
        n_cmp++; if (d != -1) begin n_err++; $display("FAIL pad_seq idx=%0d got=%02h exp=%02h", d, (d < got_q.size()) ? got_q[d] : 8'hxx, (d < exp_q.size()) ? exp_q[d] : 8'hxx); end
        n_cmp++; if (acc_cnt != 1) begin n_err++; $display("FAIL pad_accepted got=%0d exp=1", acc_cnt); end
        n_cmp++; if (ready_cnt != 1) begin n_err++; $display("FAIL pad_ready_cycles got=%0d exp=1", ready_cnt); end
        n_cmp++; if (first_flag(2, 0) != last_flag(0)) begin n_err++; $display("FAIL pad_done_pos got=%0d exp=%0d", first_flag(2, 0), last_flag(0)); end
    endtask

    task automatic test_no_pad();
        bit fin;
        int d;
        logic [7:0] body[$];
        stim_q.delete(); body.delete();
        for (int i = 0; i < 60; i++) begin
            stim_q.push_back({(i == 59), 8'(i)});
            body.push_back(8'(i));
        end
        run_stream(1, 300, fin);
        exp_q.delete(); push_pre();
        foreach (body[i]) exp_q.push_back(body[i]);
        push_fcs(ref_fcs(body));
        collect_high(); d = first_diff();
        n_cmp++; if (!fin) begin n_err++; $display("FAIL nopad_timeout got=unfinished exp=finished"); end
        n_cmp++; if (count_flag(0) != 72) begin n_err++; $display("FAIL nopad_txen_cycles got=%0d exp=72", count_flag(0)); end
        n_cmp++; if (last_flag(0) - first_flag(0, 0) + 1 != 72) begin n_err++; $display("FAIL nopad_contiguous got=%0d exp=72", last_flag(0) - first_flag(0, 0) + 1); end
        n_cmp++; if (d != -1) begin n_err++; $display("FAIL nopad_seq idx=%0d got=%02h exp=%02h", d, (d < got_q.size()) ? got_q[d] : 8'hxx, (d < exp_q.size()) ? exp_q[d] : 8'hxx); end
        n_cmp++; if (acc_cnt != 60) begin n_err++; $display("FAIL nopad_accepted got=%0d exp=60", acc_cnt); end
    endtask

    task automatic test_back_to_back();
        bit fin;
        int d, di, gap, j;
        stim_q.delete(); push_check_frame(); push_check_frame();
        run_stream(0, 300, fin);
        exp_q.delete();
        for (int f = 0; f < 2; f++) begin
            push_pre();
            for (int i = 0; i < 9; i++) exp_q.push_back(8'(8'h31 + i));
            exp_q.push_back(8'h26); exp_q.push_back(8'h39); exp_q.push_back(8'hF4); exp_q.push_back(8'hCB);
        end
        collect_high(); d = first_diff();
        di = first_flag(2, 0);
        gap = 0;
        if (di >= 0) begin
            j = di + 1;
            while (j < s_txen.size() && !s_txen[j]) begin
                gap++;
                j++;
            end
        end
        n_cmp++; if (!fin) begin n_err++; $display("FAIL b2b_timeout got=unfinished exp=finished"); end
        n_cmp++; if (d != -1) begin n_err++; $display("FAIL b2b_seq idx=%0d got=%02h exp=%02h", d, (d < got_q.size()) ? got_q[d] : 8'hxx, (d < exp_q.size()) ? exp_q[d] : 8'hxx); end
        n_cmp++; if (count_flag(2) != 2) begin n_err++; $display("FAIL b2b_done_count got=%0d exp=2", count_flag(2)); end
        n_cmp++; if (gap != 12) begin n_err++; $display("FAIL b2b_gap got=%0d exp=12", gap); end
    endtask

    task automatic test_underrun();
        bit fin;
        int d, ti, nb;
        stim_q.delete();
        for (int i = 0; i < 5; i++) stim_q.push_back({1'b0, 8'(8'h10 + i)});
        run_stream(1, 200, fin);
        exp_q.delete(); push_pre();
        for (int i = 0; i < 5; i++) exp_q.push_back(8'(8'h10 + i));
        exp_q.push_back(8'h00);
        collect_high(); d = first_diff();
        ti = first_flag(1, 0);
        nb = 0;
        if (ti >= 0) for (int i = ti; i < s_busy.size(); i++) if (s_busy[i]) nb++;
        n_cmp++; if (!fin) begin n_err++; $display("FAIL urun_timeout got=unfinished exp=finished"); end
        n_cmp++; if (d != -1) begin n_err++; $display("FAIL urun_seq idx=%0d got=%02h exp=%02h", d, (d < got_q.size()) ? got_q[d] : 8'hxx, (d < exp_q.size()) ? exp_q[d] : 8'hxx); end
        n_cmp++; if (count_flag(1) != 1) begin n_err++; $display("FAIL urun_txer_count got=%0d exp=1", count_flag(1)); end
        n_cmp++; if (ti != last_flag(0)) begin n_err++; $display("FAIL urun_txer_pos got=%0d exp=%0d", ti, last_flag(0)); end
        n_cmp++; if (count_flag(2) != 0) begin n_err++; $display("FAIL urun_done got=%0d exp=0", count_flag(2)); end
        n_cmp++; if (nb != 12) begin n_err++; $display("FAIL urun_ifg_busy got=%0d exp=12", nb); end
    endtask

    task automatic test_reset_mid_frame();
        bit fin, got_ready, busy_seen;
        int d;
        got_ready = 0;
        @(negedge clk);
        d0_valid = 1; d0_data = 8'h31; d0_last = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (d0_ready) begin
                got_ready = 1;
                break;
            end
        end
        n_cmp++; if (!got_ready) begin n_err++; $display("FAIL rstmid_reach_data got=0 exp=1"); end
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        n_cmp++; if (d0_txen !== 1'b1) begin n_err++; $display("FAIL rstmid_pre_txen got=%b exp=1", d0_txen); end
        rst = 1;
        #1;
        n_cmp++; if (d0_txen !== 1'b0) begin n_err++; $display("FAIL rstmid_txen got=%b exp=0", d0_txen); end
        n_cmp++; if (d0_txer !== 1'b0) begin n_err++; $display("FAIL rstmid_txer got=%b exp=0", d0_txer); end
        n_cmp++; if (d0_ready !== 1'b0) begin n_err++; $display("FAIL rstmid_ready got=%b exp=0", d0_ready); end
        n_cmp++; if (d0_busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got=%b exp=0", d0_busy); end
        @(negedge clk);
        d0_valid = 0; d0_data = 8'h00;
        rst = 0;
        busy_seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (d0_busy || d0_txen) busy_seen = 1;
        end
        n_cmp++; if (busy_seen) begin n_err++; $display("FAIL rstmid_no_resume got=busy exp=idle"); end
        stim_q.delete(); push_check_frame();
        run_stream(0, 200, fin);
        exp_q.delete(); push_pre();
        for (int i = 0; i < 9; i++) exp_q.push_back(8'(8'h31 + i));
        exp_q.push_back(8'h26); exp_q.push_back(8'h39); exp_q.push_back(8'hF4); exp_q.push_back(8'hCB);
        collect_high(); d = first_diff();
        n_cmp++; if (!fin) begin n_err++; $display("FAIL rstmid_timeout got=unfinished exp=finished"); end
        n_cmp++; if (d != -1) begin n_err++; $display("FAIL rstmid_seq idx=%0d got=%02h exp=%02h", d, (d < got_q.size()) ? got_q[d] : 8'hxx, (d < exp_q.size()) ? exp_q[d] : 8'hxx); end
    endtask

    initial begin
        test_reset();
        test_check_value();
        test_min_pad();
        test_no_pad();
        test_back_to_back();
        test_underrun();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
